tetris_frame_streamer: RTL and testbench

Sits directly downstream of the TETRIS engine and consumes its end-of-round outputs: tetris_valid, tetris[71:0], score and fail. It captures the final 12x6 board together with the round statistics. It then streams the capture as one header beat followed by one beat per row over a valid/ready interface toward a display/logging sink. This decouples the single-cycle TETRIS result pulse from a back-pressured consumer.

---
 rtl/tetris_stream_pkg.sv | 20 ++
 rtl/tetris_top_row.sv | 22 ++
 rtl/tetris_frame_streamer.sv | 142 ++++++++++++++
 tb/tb_tetris_frame_streamer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tetris_stream_pkg.sv
// Shared constants, FSM state type and header beat layout for the TETRIS frame streamer.
package tetris_stream_pkg;

  localparam int unsigned ROWS   = 12;
  localparam int unsigned COLS   = 6;
  localparam int unsigned RID_W  = 3;
  localparam int unsigned ROW_IW = $clog2(ROWS);

  // Header beat: {fail, round_id, score}
  localparam int unsigned FAIL_BIT  = 7;
  localparam int unsigned RID_LSB   = 4;
  localparam int unsigned SCORE_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_ROWS
  } state_e;

endpackage

// File: rtl/tetris_top_row.sv
// Combinational priority finder: index of the highest nonzero board row, plus an empty flag.
module tetris_top_row
  import tetris_stream_pkg::*;
(
  input  logic [ROWS*COLS-1:0] i_board,
  output logic [ROW_IW-1:0]    o_top,
  output logic                 o_empty
);

  always_comb begin
    o_top   = '0;
    o_empty = 1'b1;
    // Ascending scan: the last hit is the highest occupied row.
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (|i_board[r*COLS +: COLS]) begin
        o_top   = ROW_IW'(r);
        o_empty = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tetris_frame_streamer.sv
// Captures the final TETRIS board and round stats, then streams header + row beats over valid/ready.
// Optional macro SKIP_EMPTY_ROWS_EN: stop each frame at the highest nonzero row.
module tetris_frame_streamer
  import tetris_stream_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tetris_valid,
  input  logic [ROWS*COLS-1:0] tetris,
  input  logic                 score_valid,
  input  logic [3:0]           score,
  input  logic                 fail,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 overflow
);

  state_e                r_state;
  state_e                w_next;
  logic [ROWS*COLS-1:0]  r_board;
  logic [3:0]            r_score;
  logic                  r_fail;
  logic [RID_W-1:0]      r_rid;
  logic [RID_W-1:0]      r_rid_cnt;
  logic [ROW_IW-1:0]     r_row_idx;
  logic                  r_overflow;

  logic                  w_hs;
  logic                  w_last_hs;
  logic                  w_cap;
  logic                  w_drop;
  logic [COLS-1:0]       w_row;
  logic [ROW_IW-1:0]     w_last_row;
  logic                  w_head_last;

`ifdef SKIP_EMPTY_ROWS_EN
  logic [ROW_IW-1:0]     w_top;
  logic                  w_empty;
  logic [ROW_IW-1:0]     r_top;
  logic                  r_empty;

  tetris_top_row u_top_row (
    .i_board (tetris),
    .o_top   (w_top),
    .o_empty (w_empty)
  );

  assign w_last_row  = r_top;
  assign w_head_last = r_empty;
`else
  assign w_last_row  = ROW_IW'(ROWS - 1);
  assign w_head_last = 1'b0;
`endif

  assign w_row    = r_board[r_row_idx*COLS +: COLS];
  assign overflow = r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Outputs depend only on state and registers; out_ready only steers the next state.
  always_comb begin
    w_next    = r_state;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    w_hs      = 1'b0;
    w_last_hs = 1'b0;
    w_cap     = 1'b0;
    w_drop    = 1'b0;

    unique case (r_state)
      ST_HEAD: begin
        out_valid                  = 1'b1;
        busy                       = 1'b1;
        out_data[FAIL_BIT]         = r_fail;
        out_data[RID_LSB +: RID_W] = r_rid;
        out_data[SCORE_LSB +: 4]   = r_score;
        out_last                   = w_head_last;
      end
      ST_ROWS: begin
        out_valid           = 1'b1;
        busy                = 1'b1;
        out_data[COLS-1:0]  = w_row;
        out_last            = (r_row_idx == w_last_row);
      end
      default: ;
    endcase

    w_hs      = out_valid & out_ready;
    w_last_hs = w_hs & out_last;
    w_cap     = tetris_valid & ((r_state == ST_IDLE) | w_last_hs);
    w_drop    = tetris_valid & busy & ~w_last_hs;

    unique case (r_state)
      ST_IDLE: if (w_cap) w_next = ST_HEAD;
      ST_HEAD: if (w_hs) begin
        if (w_head_last) w_next = w_cap ? ST_HEAD : ST_IDLE;
        else             w_next = ST_ROWS;
      end
      ST_ROWS: if (w_last_hs) w_next = w_cap ? ST_HEAD : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_board    <= '0;
      r_score    <= '0;
      r_fail     <= 1'b0;
      r_rid      <= '0;
      r_rid_cnt  <= '0;
      r_row_idx  <= '0;
      r_overflow <= 1'b0;
`ifdef SKIP_EMPTY_ROWS_EN
      r_top      <= '0;
      r_empty    <= 1'b1;
`endif
    end else begin
      if (w_cap) begin
        r_board   <= tetris;
        r_score   <= score_valid ? score : 4'd0;
        r_fail    <= fail;
        r_rid     <= r_rid_cnt;
        r_rid_cnt <= r_rid_cnt + 1'b1;
`ifdef SKIP_EMPTY_ROWS_EN
        r_top     <= w_top;
        r_empty   <= w_empty;
`endif
      end
      if (w_drop) r_overflow <= 1'b1;
      if (w_hs)   r_row_idx  <= (r_state == ST_HEAD) ? '0 : r_row_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_tetris_frame_streamer.sv
// Directed self-checking bench for tetris_frame_streamer (default build, all rows streamed).
module tb_tetris_frame_streamer;

  typedef logic [7:0] rows_t [12];

  localparam rows_t R_A = '{8'h3B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam rows_t R_B = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                            8'h3F, 8'h2A, 8'h15, 8'h00, 8'h33, 8'h0C};
  localparam rows_t R_C = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                            8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B};
  localparam rows_t R_D = '{8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F,
                            8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
  localparam rows_t R_E = '{8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01,
                            8'h00, 8'h20, 8'h30, 8'h38, 8'h3C, 8'h3E};
  localparam rows_t R_X = '{8'h15, 8'h15, 8'h15, 8'h15, 8'h15, 8'h15,
                            8'h15, 8'h15, 8'h15, 8'h15, 8'h15, 8'h15};
  localparam rows_t R_Z = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tetris_valid;
  logic [71:0] tetris;
  logic        score_valid;
  logic [3:0]  score;
  logic        fail;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tetris_frame_streamer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tetris_valid (tetris_valid),
    .tetris       (tetris),
    .score_valid  (score_valid),
    .score        (score),
    .fail         (fail),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .overflow     (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] pack(input rows_t r);
    logic [71:0] b;
    b = '0;
    for (int k = 0; k < 12; k++) b[k*6 +: 6] = r[k][5:0];
    return b;
  endfunction

  task automatic set_in(input rows_t r, input logic [3:0] sc, input logic sv, input logic fl);
    tetris      = pack(r);
    score       = sc;
    score_valid = sv;
    fail        = fl;
  endtask

  task automatic start_frame(input rows_t r, input logic [3:0] sc, input logic sv, input logic fl);
    set_in(r, sc, sv, fl);
    tetris_valid = 1'b1;
    tick();
    tetris_valid = 1'b0;
  endtask

  // Consumes one frame; optionally pulses tetris_valid while a given beat is offered.
  task automatic recv(input string name, input logic [7:0] hdr, input rows_t r,
                      input bit bp, input int inj_beat, input rows_t ir,
                      input logic [3:0] isc, input logic isv, input logic ifl,
                      input bit inj_drop);
    int         beat = 0;
    int         cyc  = 0;
    bit         stalled = 0;
    bit         inj;
    logic       rdy;
    logic [7:0] prev = '0;
    logic [7:0] exp;
    while (beat < 13 && cyc < 200) begin
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      check({name, "_valid"}, out_valid, 1);
      check({name, "_busy"}, busy, 1);
      if (stalled) check({name, "_stable"}, out_data, prev);
      inj = (beat == inj_beat) && rdy;
      if (rdy) begin
        exp = (beat == 0) ? hdr : r[beat-1];
        check($sformatf("%s_beat%0d", name, beat), out_data, exp);
        check($sformatf("%s_last%0d", name, beat), out_last, (beat == 12));
        beat++;
      end
      stalled = !rdy;
      prev    = out_data;
      if (inj) begin
        set_in(ir, isc, isv, ifl);
        tetris_valid = 1'b1;
      end
      tick();
      tetris_valid = 1'b0;
      cyc++;
      if (inj && inj_drop) check({name, "_ovf_set"}, overflow, 1);
    end
    check({name, "_beats"}, beat, 13);
    if (!bp) check({name, "_cycles"}, cyc, 13);
  endtask

  initial begin
    rst_n        = 1'b0;
    tetris_valid = 1'b0;
    tetris       = '0;
    score_valid  = 1'b0;
    score        = '0;
    fail         = 1'b0;
    out_ready    = 1'b1;
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    tick();
    check("idle_valid", out_valid, 0);

    // rid0, fail0, score5 -> header 0x05
    start_frame(R_A, 4'd5, 1'b1, 1'b0);
    recv("f0", 8'h05, R_A, 0, -1, R_Z, 4'd0, 1'b0, 1'b0, 0);
    check("f0_idle_valid", out_valid, 0);
    check("f0_idle_busy", busy, 0);

    // rid1, fail1, score9 -> 0x99, random back-pressure
    start_frame(R_B, 4'd9, 1'b1, 1'b1);
    recv("bp", 8'h99, R_B, 1, -1, R_Z, 4'd0, 1'b0, 1'b0, 0);
    out_ready = 1'b1;
    tick();

    // rid2 0x23; next frame captured on the last handshake, score_valid=0 -> rid3 0x30
    start_frame(R_C, 4'd3, 1'b1, 1'b0);
    recv("b2b_a", 8'h23, R_C, 0, 12, R_D, 4'hC, 1'b0, 1'b0, 0);
    recv("b2b_b", 8'h30, R_D, 0, -1, R_Z, 4'd0, 1'b0, 1'b0, 0);
    check("b2b_no_ovf", overflow, 0);

    // rid4, fail1, score2 -> 0xC2; second pulse during row 4 is dropped
    start_frame(R_E, 4'd2, 1'b1, 1'b1);
    recv("drop", 8'hC2, R_E, 0, 5, R_X, 4'd7, 1'b1, 1'b0, 1);
    check("drop_idle", out_valid, 0);

    start_frame(R_B, 4'd15, 1'b1, 1'b0);            // rid5 -> 0x5F
    recv("f5", 8'h5F, R_B, 0, -1, R_Z, 4'd0, 1'b0, 1'b0, 0);
    check("ovf_sticky", overflow, 1);
    start_frame(R_A, 4'd1, 1'b1, 1'b0);             // rid6 -> 0x61
    recv("f6", 8'h61, R_A, 0, -1, R_Z, 4'd0, 1'b0, 1'b0, 0);
    start_frame(R_C, 4'd0, 1'b1, 1'b1);             // rid7 -> 0xF0
    recv("f7", 8'hF0, R_C, 0, -1, R_Z, 4'd0, 1'b0, 1'b0, 0);
    start_frame(R_E, 4'd6, 1'b1, 1'b0);             // rid wraps to 0 -> 0x06
    recv("wrap", 8'h06, R_E, 0, -1, R_Z, 4'd0, 1'b0, 1'b0, 0);

    // rid1 -> 0x10, then reset mid-row
    start_frame(R_A, 4'd0, 1'b1, 1'b0);
    check("ab_hdr", out_data, 8'h10);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    check("ab_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ab_valid", out_valid, 0);
    check("ab_data", out_data, 0);
    check("ab_last", out_last, 0);
    check("ab_busy0", busy, 0);
    check("ab_ovf", overflow, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ab_idle", out_valid, 0);

    // rid restarts at 0, score4 -> 0x04
    start_frame(R_A, 4'd4, 1'b1, 1'b0);
    recv("post_rst", 8'h04, R_A, 0, -1, R_Z, 4'd0, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
